// File: rtl/weight_sram_pkg.sv
// Shared geometry and FSM encoding for the weight SRAM load/read controller.
// No logic: constants and types only.
// No flow control here.
package weight_sram_pkg;

    localparam int ROWS   = 32;
    localparam int COLS   = 72;
    localparam int WORD_W = 32;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 7;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/weight_addr_cnt.sv
// Load address walker: column counter that wraps into a modulo-ROWS row counter.
// Updates one cycle after load_i or step_i; load_i has priority over step_i.
// No backpressure; the caller pulses step_i once per accepted write.
module weight_addr_cnt
    import weight_sram_pkg::*;
#(
    parameter int ROWS_P = ROWS,
    parameter int COLS_P = COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [ROW_W-1:0] base_i,
    input  logic [CNT_W-1:0] num_i,
    input  logic             step_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic [CNT_W-1:0] rows_left_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             col_wrap;
    logic             row_wrap;

    assign col_wrap = (col_q == COL_W'(COLS_P - 1));
    assign row_wrap = (row_q == ROW_W'(ROWS_P - 1));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        left_d = left_q;
        if (load_i) begin
            row_d  = base_i;
            col_d  = '0;
            left_d = num_i;
        end else if (step_i) begin
            if (col_wrap) begin
                col_d  = '0;
                row_d  = row_wrap ? '0 : row_q + ROW_W'(1);
                left_d = left_q - CNT_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            left_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            left_q <= left_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign rows_left_o = left_q;

endmodule

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM controller: streams row-major load words into the SRAM and arbitrates compute row reads.
// Writes land the cycle they are accepted; rd_valid follows a granted read by one cycle.
// Reads win the port and stall writes (wr_ready=0); a read of the row being loaded stalls until load ends.
module weight_sram_ctrl #(
    parameter int ROWS   = weight_sram_pkg::ROWS,
    parameter int COLS   = weight_sram_pkg::COLS,
    parameter int WORD_W = weight_sram_pkg::WORD_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_start,
    input  logic [weight_sram_pkg::ROW_W-1:0] load_row_base,
    input  logic [weight_sram_pkg::CNT_W-1:0] load_num_rows,
    input  logic                              wr_valid,
    input  logic [WORD_W-1:0]                 wr_data,
    output logic                              wr_ready,
    output logic                              load_done,
    output logic                              busy,
    input  logic                              rd_req,
    input  logic [weight_sram_pkg::ROW_W-1:0] rd_row,
    output logic                              rd_ready,
    output logic                              rd_valid,
    output logic                              sram_ceb,
    output logic                              sram_web,
    output logic [weight_sram_pkg::ROW_W-1:0] sram_a_row,
    output logic [weight_sram_pkg::COL_W-1:0] sram_a_col,
    output logic [WORD_W-1:0]                 sram_d
);

    import weight_sram_pkg::*;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic [CNT_W-1:0] rows_left;
    logic             start_load;
    logic             wr_fire;
    logic             last_word;
    logic             rd_valid_q;
    logic [COL_W-1:0] a_col_q;
    logic [WORD_W-1:0] d_q;

    assign start_load = (state_q == IDLE) && load_start && (load_num_rows != '0);
    assign wr_fire    = wr_valid && wr_ready;
    assign last_word  = (rows_left == CNT_W'(1)) && (cur_col == COL_W'(COLS - 1));

    weight_addr_cnt #(
        .ROWS_P (ROWS),
        .COLS_P (COLS)
    ) u_addr_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (start_load),
        .base_i      (load_row_base),
        .num_i       (load_num_rows),
        .step_i      (wr_fire),
        .row_o       (cur_row),
        .col_o       (cur_col),
        .rows_left_o (rows_left)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = (load_num_rows != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (wr_fire && last_word) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All handshake and SRAM strobes are forced idle while reset is held, independent of state.
    always_comb begin
        busy       = 1'b0;
        load_done  = 1'b0;
        rd_ready   = 1'b0;
        wr_ready   = 1'b0;
        sram_ceb   = 1'b1;
        sram_web   = 1'b1;
        sram_a_row = cur_row;
        sram_a_col = a_col_q;
        sram_d     = d_q;
        if (rst_n) begin
            busy      = (state_q == LOAD);
            load_done = (state_q == DONE);
            rd_ready  = rd_req && !(busy && (rd_row == cur_row));
            wr_ready  = busy && !rd_ready;
            if (rd_ready) begin
                sram_ceb   = 1'b0;
                sram_a_row = rd_row;
            end else if (wr_valid && wr_ready) begin
                sram_ceb   = 1'b0;
                sram_web   = 1'b0;
                sram_a_col = cur_col;
                sram_d     = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            a_col_q    <= '0;
            d_q        <= '0;
        end else begin
            rd_valid_q <= rd_ready;
            if (wr_fire) begin
                a_col_q <= cur_col;
                d_q     <= wr_data;
            end
        end
    end

    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: directed load/read/reset scenarios plus randomized traffic,
// checked every cycle against a write-index reference model and a shadow SRAM.
module tb_weight_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [4:0]  load_row_base;
    logic [5:0]  load_num_rows;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        load_done;
    logic        busy;
    logic        rd_req;
    logic [4:0]  rd_row;
    logic        rd_ready;
    logic        rd_valid;
    logic        sram_ceb;
    logic        sram_web;
    logic [4:0]  sram_a_row;
    logic [6:0]  sram_a_col;
    logic [31:0] sram_d;

    always #5 clk = ~clk;

    weight_sram_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_row_base (load_row_base),
        .load_num_rows (load_num_rows),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .load_done     (load_done),
        .busy          (busy),
        .rd_req        (rd_req),
        .rd_row        (rd_row),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .sram_ceb      (sram_ceb),
        .sram_web      (sram_web),
        .sram_a_row    (sram_a_row),
        .sram_a_col    (sram_a_col),
        .sram_d        (sram_d)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_mem [32][72];
    logic [31:0] dut_mem [32][72];
    int          obs_writes = 0;

    // Reference model: a load is the word index k into a row-major stream starting at m_base.
    bit          m_loading, m_done, m_prev_grant, m_have_last;
    int          m_base, m_num, m_k;
    logic [6:0]  m_last_col;
    logic [31:0] m_last_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        int cur_row;
        bit e_busy, e_done, e_rd, e_wr_rdy, e_wr, next_done, was_idle;
        @(negedge clk);
        cur_row  = (m_base + m_k / 72) % 32;
        e_busy   = rst_n && m_loading;
        e_done   = rst_n && m_done;
        e_rd     = rst_n && rd_req && !(e_busy && (rd_row == 5'(cur_row)));
        e_wr_rdy = e_busy && !e_rd;
        e_wr     = e_wr_rdy && wr_valid;
        chk("busy", busy, e_busy);
        chk("load_done", load_done, e_done);
        chk("rd_ready", rd_ready, e_rd);
        chk("wr_ready", wr_ready, e_wr_rdy);
        chk("rd_valid", rd_valid, m_prev_grant);
        chk("sram_ceb", sram_ceb, !(e_rd || e_wr));
        chk("sram_web", sram_web, !e_wr);
        if (e_rd) chk("rd_a_row", sram_a_row, rd_row);
        if (e_wr) begin
            chk("wr_a_row", sram_a_row, cur_row);
            chk("wr_a_col", sram_a_col, m_k % 72);
            chk("wr_d", sram_d, wr_data);
        end else if (m_have_last) begin
            chk("hold_a_col", sram_a_col, m_last_col);
            chk("hold_d", sram_d, m_last_d);
        end
        if (sram_ceb === 1'b0 && sram_web === 1'b0) begin
            obs_writes++;
            if (sram_a_col < 7'd72) dut_mem[sram_a_row][sram_a_col] = sram_d;
        end
        if (!rst_n) begin
            m_loading    = 1'b0;
            m_done       = 1'b0;
            m_prev_grant = 1'b0;
            m_have_last  = 1'b0;
        end else begin
            was_idle     = !e_busy && !e_done;
            m_prev_grant = e_rd;
            next_done    = 1'b0;
            if (e_wr) begin
                exp_mem[cur_row][m_k % 72] = wr_data;
                m_last_col  = 7'(m_k % 72);
                m_last_d    = wr_data;
                m_have_last = 1'b1;
                m_k++;
                if (m_k == m_num * 72) begin
                    m_loading = 1'b0;
                    next_done = 1'b1;
                end
            end
            if (load_start && was_idle) begin
                if (load_num_rows != 6'd0) begin
                    m_loading = 1'b1;
                    m_base    = int'(load_row_base);
                    m_num     = int'(load_num_rows);
                    m_k       = 0;
                end else begin
                    next_done = 1'b1;
                end
            end
            m_done = next_done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int b, input int n);
        load_row_base = 5'(b);
        load_num_rows = 6'(n);
        load_start    = 1'b1;
        step();
        load_start    = 1'b0;
    endtask

    // Drive until the model reports the load finished; vld_pct/rd_pct shape random traffic.
    task automatic run(input int max, input int vld_pct, input int rd_pct);
        int n = 0;
        while ((m_loading || m_done) && n < max) begin
            wr_data  = $urandom;
            wr_valid = ($urandom_range(99) < vld_pct);
            rd_req   = ($urandom_range(99) < rd_pct);
            rd_row   = 5'($urandom_range(31));
            step();
            n++;
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("run_end_busy", busy, 1'b0);
    endtask

    function automatic int mem_diff(input int r0, input int r1);
        int d = 0;
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < 72; c++)
                if (dut_mem[r][c] !== exp_mem[r][c]) d++;
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 72; c++) begin
                exp_mem[r][c] = '0;
                dut_mem[r][c] = '0;
            end
        m_loading = 0; m_done = 0; m_prev_grant = 0; m_have_last = 0;
        m_base = 0; m_num = 0; m_k = 0; m_last_col = '0; m_last_d = '0;
        rst_n = 1'b0; load_start = 1'b0; load_row_base = '0; load_num_rows = '0;
        wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; rd_row = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, including a request presented while reset is held.
        rd_req = 1'b1; wr_valid = 1'b1;
        step();
        chk("rst_ceb", sram_ceb, 1'b1);
        chk("rst_rd_ready", rd_ready, 1'b0);
        rd_req = 1'b0; wr_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Two-row load from row 3, wr_valid held high.
        start(3, 2);
        w = obs_writes;
        run(400, 100, 0);
        chk("s1_writes", obs_writes - w, 144);
        chk("s1_mem_rows_3_4", mem_diff(3, 4), 0);

        // Row wrap 31 -> 0.
        start(31, 2);
        w = obs_writes;
        run(400, 100, 0);
        chk("s2_writes", obs_writes - w, 144);
        chk("s2_mem_row31", mem_diff(31, 31), 0);
        chk("s2_mem_row0", mem_diff(0, 0), 0);

        // Read of another row preempts the write at row 5 col 10.
        start(5, 1);
        wr_valid = 1'b1;
        repeat (10) begin wr_data = $urandom; step(); end
        rd_req = 1'b1; rd_row = 5'd7; wr_data = $urandom;
        w = obs_writes;
        step();
        chk("s3_no_write", obs_writes - w, 0);
        chk("s3_rd_valid", rd_valid, 1'b1);
        rd_req = 1'b0;
        #1;
        chk("s3_col_held", sram_a_col, 7'd10);
        run(200, 100, 0);

        // Read of the row being loaded stalls until the load ends.
        start(5, 1);
        wr_valid = 1'b1; rd_req = 1'b1; rd_row = 5'd5;
        w = 0;
        while ((m_loading || m_done) && w < 200) begin wr_data = $urandom; step(); w++; end
        wr_valid = 1'b0;
        #1;
        chk("s4_grant_after", rd_ready, 1'b1);
        step();
        rd_req = 1'b0;

        // Zero-row load, then load_start while busy.
        w = obs_writes;
        start(9, 0);
        chk("s5_done_pulse", load_done, 1'b1);
        step();
        chk("s5_done_once", load_done, 1'b0);
        chk("s5_no_writes", obs_writes - w, 0);
        start(10, 1);
        wr_valid = 1'b1;
        repeat (5) begin wr_data = $urandom; step(); end
        start(20, 3);
        run(200, 100, 0);
        chk("s5_ignored_writes", obs_writes - w, 72);

        // Reset mid-load at row 2 col 40, then a fresh load from row 0.
        start(2, 1);
        wr_valid = 1'b1;
        repeat (40) begin wr_data = $urandom; step(); end
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_wr_ready", wr_ready, 1'b0);
        chk("s6_rst_ceb", sram_ceb, 1'b1);
        chk("s6_rst_web", sram_web, 1'b1);
        step();
        rst_n = 1'b1;
        w = obs_writes;
        repeat (3) step();
        chk("s6_no_writes", obs_writes - w, 0);
        chk("s6_no_done", load_done, 1'b0);
        start(0, 1);
        run(200, 100, 0);

        // Randomized loads with random valid gaps and interleaved reads.
        for (int t = 0; t < 4; t++) begin
            start($urandom_range(31), $urandom_range(1, 2));
            run(900, 70, 25);
        end
        chk("final_mem", mem_diff(0, 31), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/weight_sram_ctrl.md
WEIGHT_SRAM_CTRL -- requirements
Module: weight_sram_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ROWS, 32, SRAM rows
- COLS, 72, 32-bit words per row (2304/32)
- WORD_W, 32, write word width

REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- load_start  in  1  one-cycle pulse that starts a load
- load_row_base  in  5  first row of the load
- load_num_rows  in  6  rows to load, 0..32
- wr_valid  in  1  write word available
- wr_data  in  32  write word
- wr_ready  out  1  controller accepts wr_data this cycle
- load_done  out  1  one-cycle pulse after the last load word is written
- busy  out  1  load in progress
- rd_req  in  1  compute-side row read request
- rd_row  in  5  row to read
- rd_ready  out  1  read granted this cycle
- rd_valid  out  1  SRAM Q holds the requested row this cycle
- sram_ceb  out  1  SRAM chip enable, active low
- sram_web  out  1  SRAM write enable, active low
- sram_a_row  out  5  SRAM row address
- sram_a_col  out  7  SRAM column (word) address, 0..71
- sram_d  out  32  SRAM write data

Function
REQ-003 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-004 In IDLE, load_start with load_num_rows>0 SHALL latch the base and count, set col=0 and rows_left=load_num_rows, and enter LOAD; busy=1 from the next cycle.
REQ-005 load_start with load_num_rows=0 SHALL go IDLE->DONE with no SRAM writes.
REQ-006 load_start outside IDLE SHALL be ignored.
REQ-007 In LOAD, wr_ready SHALL equal !(rd_req && rd_ready).
REQ-008 A write SHALL occur in any cycle with wr_valid && wr_ready; in that cycle sram_ceb=0, sram_web=0, sram_a_row=current row, sram_a_col=col, sram_d=wr_data.
REQ-009 After each write, col SHALL increment; at col=71 it SHALL wrap to 0, row SHALL increment modulo 32 (row 31 wraps to 0), and rows_left SHALL decrement.
REQ-010 The write that takes rows_left from 1 to 0 SHALL move the FSM to DONE.
REQ-011 DONE SHALL last exactly one cycle with load_done=1 and busy=0, then return to IDLE.
REQ-012 rd_ready SHALL be rd_req && !(busy && rd_row==current load row); a read of the row currently being loaded SHALL stall.
REQ-013 Reads SHALL have priority over writes; at most one SRAM access SHALL occur per cycle.
REQ-014 In a cycle with rd_req && rd_ready: sram_ceb=0, sram_web=1, sram_a_row=rd_row.
REQ-015 rd_valid SHALL assert exactly one cycle after each granted read, aligned with registered SRAM Q; back-to-back reads SHALL give rd_valid on consecutive cycles.
REQ-016 With no access, sram_ceb=1 and sram_web=1; sram_a_col and sram_d SHALL hold their last values.
REQ-017 wr_valid outside LOAD SHALL be ignored and wr_ready SHALL be 0.
REQ-018 sram_ceb, sram_web and wr_ready SHALL be combinational from state and the current request.

Reset
REQ-019 While rst_n=0 at a clock edge: FSM=IDLE, col=0, row=0, rows_left=0, rd_valid=0.
REQ-020 While rst_n=0 the outputs SHALL be: load_done=0, busy=0, wr_ready=0, rd_ready=0, sram_ceb=1, sram_web=1.
REQ-021 Reset during LOAD SHALL abort the load: no load_done pulse, no further writes.

Structure
REQ-022 Package weight_sram_pkg SHALL hold ROWS, COLS, WORD_W, the row width (5), the column width (7) and the FSM state enum.
REQ-023 The row/column auto-increment counter with wrap SHALL be the sub-module weight_addr_cnt; all other logic SHALL be flat.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load base=3, num=2, wr_valid always high -> 144 writes (row 3 cols 0..71, then row 4); load_done one cycle after write 144; SRAM model contents match.
- Load base=31, num=2 -> writes go to row 31 then row 0.
- During a load at row 5, col 10, rd_req with rd_row=7 -> wr_ready=0 that cycle, no write, col stays 10; rd_valid the next cycle; loading resumes.
- rd_req with rd_row=5 while row 5 is loading -> rd_ready=0 until load_done; then the read is granted.
- load_num_rows=0 -> load_done the next cycle, zero SRAM writes; load_start during busy -> ignored.
- rst_n=0 at row 2, col 40 -> all outputs at reset values, no load_done; a new load from base 0 starts at col 0.
